cnt_load_arbiter: RTL and testbench
===================================

// Module: cnt_load_arbiter
// PURPOSE
//  Round-robin scheduler sharing one 8-bit down-counter (ports clk, rst, ld, data, cnt, val) between NREQ requesters.
//  Grants one requester at a time, latches its load value, pulses ld/data into the counter, then waits for completion.
//  Reports per-requester done, or err when a WAIT_MAX watchdog expires. Sits between requesters and the counter instance.
//  Counter contract: ld=1 at an edge -> cnt<=data; otherwise cnt decrements when nonzero; val=1 iff cnt==0.
// PARAMETERS
//  NREQ      4    number of requesters (2..8)
//  W         8    load-value width; equals the counter data width
//  WAIT_MAX  255  max WAIT cycles before abort (>=1)
// PORTS
//  clk       in   1        single clock, rising edge
//  rst       in   1        reset, asynchronous, active-high
//  req       in   NREQ     level request per requester; held until gnt
//  req_data  in   NREQ*W   load value; slice i = req_data[i*W +: W]
//  gnt       out  NREQ     one-hot, high exactly during the LOAD cycle
//  done      out  NREQ     one-hot 1-cycle pulse: owner's count reached zero
//  err       out  1        1-cycle pulse: watchdog abort
//  ld        out  1        counter load strobe
//  data      out  W        counter load value (latched)
//  cnt       in   W        counter value (observed only)
//  val       in   1        counter at zero
//  busy      out  1        high in LOAD/WAIT/FIN
//  owner     out  $clog2(NREQ)  index of current/last grantee
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; gnt, done, err, ld, busy = 0; data=0; owner=0; rr_ptr=0; wdog=0.
//  All outputs registered or decoded from state register only; no combinational path from req to outputs.
//  FSM IDLE -> LOAD -> WAIT -> FIN -> IDLE.
//  IDLE: if |req, pick first asserted index scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//    At that edge: owner<=pick, data<=req_data slice, state<=LOAD. req sampled only in IDLE.
//  LOAD (exactly 1 cycle): ld=1, gnt[owner]=1; wdog<=0; ->WAIT.
//  WAIT: the first WAIT cycle sees cnt==data.
//    If val=1: ->FIN with done[owner] set for the FIN cycle.
//    Else wdog++; if wdog==WAIT_MAX-1 and val=0: ->FIN with err set for the FIN cycle (done stays 0).
//  FIN (1 cycle): done or err pulse visible; rr_ptr<=owner+1 mod NREQ; ->IDLE.
//  Latency: req seen in IDLE at edge E -> ld/gnt during cycle E..E+1.
//    data=D: done high 2+D cycles after the LOAD cycle (D=0 -> FIN is 2 cycles after LOAD).
//  Back-to-back minimum: a new LOAD no earlier than 2 cycles after FIN (IDLE, then LOAD).
//  Simultaneous requests: round-robin only; no starvation — every held req is granted within NREQ transactions.
//  req dropped before grant: not granted; no state. req changes during LOAD/WAIT/FIN: ignored.
//  ld is never asserted outside LOAD; never two grants without an intervening FIN.
//  Reset mid-transaction: abort silently; no done/err pulse; counter is not touched (ld=0).
//  rr_ptr wrap: owner=NREQ-1 -> rr_ptr=0.
// TESTING
//  1 Reset: assert rst mid-WAIT (data=8'd20) -> next cycle all outputs 0, state IDLE, no done/err; after release, req[1] regrants cleanly.
//  2 Single: req[2]=1, data slice=8'd5 -> one ld pulse with data=5, gnt=4'b0100 same cycle; done=4'b0100 exactly 7 cycles after LOAD; busy low after.
//  3 Fairness: req=4'b1111 held, all slices 8'd1 -> grant order 0,1,2,3,0 (pointer wrap); each gnt one-hot; no req skipped.
//  4 Zero load: req[3], data 8'd0 -> done[3] in FIN 2 cycles after LOAD; no err.
//  5 Watchdog: WAIT_MAX=4, bench holds val=0 -> err pulses once 5 cycles after LOAD; done stays 0; arbiter returns to IDLE and serves next req.
//  6 Ignore: req[0] toggles during WAIT of owner 1 -> no extra ld; owner stays 1 until FIN; req[0] granted next.

Source files
------------

// File: rtl/cnt_load_arbiter_if.sv
// Bundle between the requesters, the shared down-counter and the arbiter.
// The slave modport is the arbiter's side; master is the surrounding environment.
interface cnt_load_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              err;
    logic              ld;
    logic [W-1:0]      data;
    logic [W-1:0]      cnt;
    logic              val;
    logic              busy;
    logic [OW-1:0]     owner;

    modport master (
        output req, req_data, cnt, val,
        input  gnt, done, err, ld, data, busy, owner
    );

    modport slave (
        input  req, req_data, cnt, val,
        output gnt, done, err, ld, data, busy, owner
    );
endinterface

// File: rtl/cnt_load_arbiter.sv
// Round-robin arbiter sharing one down-counter between NREQ requesters,
// with a watchdog that aborts a run whose counter never reaches zero.
//
// state  | meaning
// IDLE   | waiting for any req; picks next requester round-robin
// LOAD   | one cycle: ld and gnt[owner] high, counter loads data
// WAIT   | waiting for val; watchdog counts cycles without val
// FIN    | one cycle: done[owner] or err pulse, advance rr pointer
module cnt_load_arbiter #(
    parameter int NREQ     = 4,
    parameter int W        = 8,
    parameter int WAIT_MAX = 255
) (
    input logic               clk,
    input logic               rst,
    cnt_load_arbiter_if.slave bus
);
    localparam int              PW       = $clog2(NREQ);
    localparam int              WDW      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WDW-1:0]  WD_LAST  = WDW'(WAIT_MAX - 1);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);
    localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_FIN} state_t;

    state_t         state, state_nx;
    logic [PW-1:0]  owner_q, rr_ptr, pick, idx;
    logic [PW:0]    sum;
    logic [W-1:0]   data_q, data_pick;
    logic [WDW-1:0] wdog;
    logic           fin_ok, fin_err, found, wd_hit;

    // first asserted request scanning upward from rr_ptr, wrapping at NREQ
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
            idx = sum[PW-1:0];
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        data_pick = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == pick) data_pick = bus.req_data[i*W +: W];
        end
    end

    assign wd_hit = (wdog == WD_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (|bus.req) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_WAIT;
            S_WAIT:  if (bus.val || wd_hit) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            owner_q <= '0;
            data_q  <= '0;
            rr_ptr  <= '0;
            wdog    <= '0;
            fin_ok  <= 1'b0;
            fin_err <= 1'b0;
        end else begin
            state   <= state_nx;
            // both flags can only be set on the WAIT->FIN edge, so they are FIN-cycle pulses
            fin_ok  <= (state == S_WAIT) && bus.val;
            fin_err <= (state == S_WAIT) && !bus.val && wd_hit;
            if (state == S_IDLE && |bus.req) begin
                owner_q <= pick;
                data_q  <= data_pick;
            end
            if (state == S_LOAD)
                wdog <= '0;
            else if (state == S_WAIT && !bus.val)
                wdog <= wdog + 1'b1;
            if (state == S_FIN)
                rr_ptr <= (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        end
    end

    assign bus.ld    = (state == S_LOAD);
    assign bus.gnt   = (state == S_LOAD) ? (ONE << owner_q) : '0;
    assign bus.done  = fin_ok ? (ONE << owner_q) : '0;
    assign bus.err   = fin_err;
    assign bus.busy  = (state != S_IDLE);
    assign bus.data  = data_q;
    assign bus.owner = owner_q;
endmodule

// File: tb/tb_cnt_load_arbiter.sv
// Bench for cnt_load_arbiter: two instances (default watchdog and WAIT_MAX=4),
// each with its own counter, checked every cycle against a transaction-timeline model.
module tb_cnt_load_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int OW  = 2;
    localparam int WM0 = 255;
    localparam int WM1 = 4;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [N-1:0]  done;
        logic          err;
        logic          ld;
        logic          busy;
        logic [W-1:0]  data;
        logic [OW-1:0] owner;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   force1 = 1'b0;
    logic [W-1:0] c0, c1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    cnt_load_arbiter_if #(.NREQ(N), .W(W)) b0 ();
    cnt_load_arbiter_if #(.NREQ(N), .W(W)) b1 ();

    cnt_load_arbiter #(.NREQ(N), .W(W), .WAIT_MAX(WM0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    cnt_load_arbiter #(.NREQ(N), .W(W), .WAIT_MAX(WM1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    // shared counters following the counter contract
    always @(posedge clk or posedge rst) begin
        if (rst) c0 <= '0;
        else if (b0.ld) c0 <= b0.data;
        else if (c0 != '0) c0 <= c0 - 1'b1;
    end
    always @(posedge clk or posedge rst) begin
        if (rst) c1 <= '0;
        else if (b1.ld) c1 <= b1.data;
        else if (c1 != '0) c1 <= c1 - 1'b1;
    end
    assign b0.cnt = c0;
    assign b0.val = (c0 == '0);
    assign b1.cnt = c1;
    assign b1.val = (c1 == '0) && !force1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic obs_t obs(input int k);
        obs_t o;
        if (k == 0) o = '{b0.gnt, b0.done, b0.err, b0.ld, b0.busy, b0.data, b0.owner};
        else        o = '{b1.gnt, b1.done, b1.err, b1.ld, b1.busy, b1.data, b1.owner};
        return o;
    endfunction

    // model: each transaction is a LOAD cycle mL and a FIN cycle mF on the cycle timeline
    int mL[2], mF[2], mown[2], mdat[2], mrr[2];
    bit mhave[2], mabt[2];

    always @(posedge clk) begin : model
        logic [N-1:0]   r;
        logic [N*W-1:0] rd;
        int wm;
        bit fz;
        for (int k = 0; k < 2; k++) begin
            r  = (k == 0) ? b0.req : b1.req;
            rd = (k == 0) ? b0.req_data : b1.req_data;
            if (rst) begin
                mhave[k] = 1'b0; mown[k] = 0; mdat[k] = 0; mrr[k] = 0;
            end else begin
                if (mhave[k] && cyc == mF[k]) mrr[k] = (mown[k] + 1) % N;
                if ((!mhave[k] || cyc > mF[k]) && r != '0) begin
                    for (int j = 0; j < N; j++) begin
                        if (r[(mrr[k] + j) % N]) begin
                            mown[k] = (mrr[k] + j) % N;
                            break;
                        end
                    end
                    mdat[k]  = int'(rd[mown[k]*W +: W]);
                    mL[k]    = cyc + 1;
                    wm       = (k == 0) ? WM0 : WM1;
                    fz       = (k == 1) && force1;
                    // counter hits zero D cycles into WAIT; watchdog allows WAIT_MAX WAIT cycles
                    if (fz || mdat[k] > wm - 1) begin
                        mF[k] = mL[k] + 1 + wm; mabt[k] = 1'b1;
                    end else begin
                        mF[k] = mL[k] + 2 + mdat[k]; mabt[k] = 1'b0;
                    end
                    mhave[k] = 1'b1;
                end
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin : compare
        obs_t a, e;
        for (int k = 0; k < 2; k++) begin
            a = obs(k);
            e = '0;
            if (!rst) begin
                e.owner = OW'(mown[k]);
                e.data  = W'(mdat[k]);
                if (mhave[k]) begin
                    e.ld   = (cyc == mL[k]);
                    e.gnt  = e.ld ? (N'(1) << mown[k]) : '0;
                    e.busy = (cyc >= mL[k]) && (cyc <= mF[k]);
                    if (cyc == mF[k]) begin
                        if (mabt[k]) e.err = 1'b1;
                        else         e.done = N'(1) << mown[k];
                    end
                end
            end
            chk($sformatf("u%0d.gnt", k),   a.gnt,   e.gnt);
            chk($sformatf("u%0d.done", k),  a.done,  e.done);
            chk($sformatf("u%0d.err", k),   a.err,   e.err);
            chk($sformatf("u%0d.ld", k),    a.ld,    e.ld);
            chk($sformatf("u%0d.busy", k),  a.busy,  e.busy);
            chk($sformatf("u%0d.data", k),  a.data,  e.data);
            chk($sformatf("u%0d.owner", k), a.owner, e.owner);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ld(input int k, output int at);
        obs_t o;
        at = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            o = obs(k);
            if (o.ld) begin at = cyc; break; end
        end
        chk("ld_seen", (at >= 0), 1);
    endtask

    task automatic wait_fin(input int k, output int at, output obs_t fo, output int nld);
        obs_t o;
        at = -1; nld = 0; fo = '0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            o = obs(k);
            if (o.ld) nld++;
            if (o.done != '0 || o.err) begin at = cyc; fo = o; break; end
        end
        chk("fin_seen", (at >= 0), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "time limit");
    end

    initial begin : drive
        int L, F, n;
        obs_t o;
        logic [N-1:0] gl [5];
        logic [N-1:0] exp_order [5];
        logic [N-1:0] r;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        b0.req = '0; b0.req_data = '0;
        b1.req = '0; b1.req_data = '0;
        repeat (3) step();
        rst = 1'b0;

        // single request, data 5
        step();
        b0.req_data[2*W +: W] = 8'd5; b0.req = 4'b0100;
        wait_ld(0, L);
        o = obs(0);
        chk("t2_data", o.data, 5);
        chk("t2_gnt", o.gnt, 4'b0100);
        step(); b0.req = '0;
        wait_fin(0, F, o, n);
        chk("t2_lat", F - L, 7);
        chk("t2_done", o.done, 4'b0100);
        chk("t2_model_lat", mF[0] - mL[0], 7);
        @(negedge clk);
        o = obs(0);
        chk("t2_busy_after", o.busy, 0);

        // zero load
        step();
        b0.req_data[3*W +: W] = 8'd0; b0.req = 4'b1000;
        wait_ld(0, L);
        step(); b0.req = '0;
        wait_fin(0, F, o, n);
        chk("t4_lat", F - L, 2);
        chk("t4_done", o.done, 4'b1000);
        chk("t4_err", o.err, 0);

        // fairness from a fresh pointer
        step(); rst = 1'b1;
        step(); step(); rst = 1'b0;
        for (int i = 0; i < N; i++) b0.req_data[i*W +: W] = 8'd1;
        b0.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_ld(0, L);
            o = obs(0);
            gl[g] = o.gnt;
        end
        step(); b0.req = '0;
        for (int g = 0; g < 5; g++) chk($sformatf("t3_grant%0d", g), gl[g], exp_order[g]);
        wait_fin(0, F, o, n);
        chk("t3_last_done", o.done, 4'b0001);

        // requests ignored while another owner runs
        step();
        b0.req_data[1*W +: W] = 8'd10; b0.req = 4'b0010;
        wait_ld(0, L);
        o = obs(0);
        chk("t6_gnt1", o.gnt, 4'b0010);
        step(); b0.req = '0;
        b0.req_data[0*W +: W] = 8'd3;
        for (int t = 0; t < 6; t++) begin
            step(); b0.req[0] = ~b0.req[0];
        end
        step(); b0.req[0] = 1'b1;
        wait_fin(0, F, o, n);
        chk("t6_extra_ld", n, 0);
        chk("t6_owner", o.owner, 1);
        chk("t6_done", o.done, 4'b0010);
        wait_ld(0, L);
        o = obs(0);
        chk("t6_next_gnt", o.gnt, 4'b0001);
        step(); b0.req = '0;
        wait_fin(0, F, o, n);
        chk("t6_next_done", o.done, 4'b0001);

        // reset mid-WAIT
        step();
        b0.req_data[0*W +: W] = 8'd20; b0.req = 4'b0001;
        wait_ld(0, L);
        step(); b0.req = '0;
        repeat (4) step();
        rst = 1'b1;
        @(negedge clk);
        o = obs(0);
        chk("t1_busy", o.busy, 0);
        chk("t1_ld", o.ld, 0);
        chk("t1_gnt", o.gnt, 0);
        chk("t1_done", o.done, 0);
        chk("t1_err", o.err, 0);
        chk("t1_data", o.data, 0);
        step(); step(); rst = 1'b0;
        b0.req_data[1*W +: W] = 8'd2; b0.req = 4'b0010;
        wait_ld(0, L);
        o = obs(0);
        chk("t1_regrant", o.gnt, 4'b0010);
        step(); b0.req = '0;
        wait_fin(0, F, o, n);
        chk("t1_regrant_done", o.done, 4'b0010);

        // watchdog on the WAIT_MAX=4 instance
        step();
        force1 = 1'b1;
        b1.req_data[1*W +: W] = 8'd9; b1.req = 4'b0010;
        wait_ld(1, L);
        step(); b1.req = '0;
        wait_fin(1, F, o, n);
        chk("t5_lat", F - L, 5);
        chk("t5_err", o.err, 1);
        chk("t5_done", o.done, 0);
        step();
        b1.req_data[2*W +: W] = 8'd3; b1.req = 4'b0100;
        wait_ld(1, L);
        o = obs(1);
        chk("t5_next_gnt", o.gnt, 4'b0100);
        step(); b1.req = '0;
        wait_fin(1, F, o, n);
        chk("t5_next_err", o.err, 1);
        step(); force1 = 1'b0;

        // randomized traffic on both instances
        for (int it = 0; it < 3000; it++) begin
            step();
            if (rst) rst = 1'b0;
            else if ($urandom_range(599) == 0) rst = 1'b1;
            for (int k = 0; k < 2; k++) begin
                o = obs(k);
                r = (k == 0) ? b0.req : b1.req;
                for (int i = 0; i < N; i++) begin
                    if (r[i]) begin
                        if (o.gnt[i] || $urandom_range(39) == 0) r[i] = 1'b0;
                    end else if ($urandom_range(5) == 0) begin
                        r[i] = 1'b1;
                        if (k == 0) b0.req_data[i*W +: W] = W'($urandom_range(15));
                        else        b1.req_data[i*W +: W] = W'($urandom_range(7));
                    end
                end
                if (k == 0) b0.req = r;
                else        b1.req = r;
            end
        end
        step(); rst = 1'b0; b0.req = '0; b1.req = '0;
        repeat (40) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
